ysyx_25040111_abt: RTL

YSYX_25040111_ABT -- requirements
Module: ysyx_25040111_abt

---
 rtl/ysyx_25040111_abt.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_25040111_abt.sv
// ysyx_25040111_abt: load/store arbiter and writeback stage.
// Accepts one op at a time from execute, issues at most one bus access,
// then writes GPR/CSR results or reports a fault in a single WB cycle.
// Handshake: a request transfers on a rising clock edge where
// abt_valid & abt_ready; the bus request transfers where mem_valid & mem_ready,
// and mem_valid holds with a stable payload until that edge.
module ysyx_25040111_abt (
    input  logic        clock,
    input  logic        reset,
    // execute-side request
    input  logic        abt_valid,
    output logic        abt_ready,
    input  logic        abt_men,
    input  logic        abt_write,
    input  logic [31:0] abt_addr,
    input  logic [31:0] abt_wdata,
    input  logic [1:0]  abt_mask,
    input  logic        abt_rsign,
    input  logic [4:0]  abt_ard,
    input  logic [31:0] abt_rd,
    input  logic        abt_gen,
    input  logic [11:0] abt_acsr,
    input  logic [31:0] abt_csr,
    input  logic        abt_sen,
    input  logic [31:0] abt_pc,
    // completion
    output logic        abt_finish,
    output logic [4:0]  abt_frd,
    // memory bus
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rerr,
    // register file write ports
    output logic        gpr_wen,
    output logic [4:0]  gpr_waddr,
    output logic [31:0] gpr_wdata,
    output logic        csr_wen,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    // fault report
    output logic        lsu_err,
    output logic [3:0]  lsu_errtp,
    output logic [31:0] lsu_epc,
    // FSM state for observation
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_WB   = 2'd3
    } state_e;

    typedef struct packed {
        logic        men;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  mask;
        logic        rsign;
        logic [4:0]  ard;
        logic [31:0] rd;
        logic        gen;
        logic [11:0] acsr;
        logic [31:0] csr;
        logic        sen;
        logic [31:0] pc;
    } payload_t;

    state_e      state_q, state_d;
    payload_t    pl_q, pl_d;
    payload_t    in_pl, cur_pl;
    logic        ready_q, ready_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_wen_q, mem_wen_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic        gpr_wen_q, gpr_wen_d;
    logic [4:0]  gpr_waddr_q, gpr_waddr_d;
    logic [31:0] gpr_wdata_q, gpr_wdata_d;
    logic        csr_wen_q, csr_wen_d;
    logic [11:0] csr_waddr_q, csr_waddr_d;
    logic [31:0] csr_wdata_q, csr_wdata_d;
    logic        finish_q, finish_d;
    logic [4:0]  frd_q, frd_d;
    logic        err_q, err_d;
    logic [3:0]  errtp_q, errtp_d;
    logic [31:0] epc_q, epc_d;

    logic        enter_wb;
    logic        cur_mis;
    logic        cur_rerr;
    logic        fault;
    logic        is_store;
    logic        is_load;
    logic [3:0]  strb;
    logic [31:0] shifted;
    logic [31:0] load_data;

    assign in_pl = '{men: abt_men, write: abt_write, addr: abt_addr,
                     wdata: abt_wdata, mask: abt_mask, rsign: abt_rsign,
                     ard: abt_ard, rd: abt_rd, gen: abt_gen, acsr: abt_acsr,
                     csr: abt_csr, sen: abt_sen, pc: abt_pc};

    // Operand view: live inputs while accepting in IDLE, latched payload afterwards.
    always_comb begin
        cur_pl    = (state_q == S_IDLE) ? in_pl : pl_q;
        cur_mis   = cur_pl.men &
                    (((cur_pl.mask == 2'b10) & cur_pl.addr[0]) |
                     ((cur_pl.mask == 2'b11) & (cur_pl.addr[1:0] != 2'b00)));
        cur_rerr  = (state_q == S_RESP) & mem_rerr;
        fault     = cur_mis | cur_rerr;
        is_store  = cur_pl.men & cur_pl.write;
        is_load   = cur_pl.men & ~cur_pl.write;
        case (cur_pl.mask)
            2'b10:   strb = 4'b0011 << {cur_pl.addr[1], 1'b0};
            2'b11:   strb = 4'b1111;
            default: strb = 4'b0001 << cur_pl.addr[1:0];
        endcase
        shifted = mem_rdata >> {cur_pl.addr[1:0], 3'b000};
        case (cur_pl.mask)
            2'b10:   load_data = {{16{cur_pl.rsign & shifted[15]}}, shifted[15:0]};
            2'b11:   load_data = shifted;
            default: load_data = {{24{cur_pl.rsign & shifted[7]}}, shifted[7:0]};
        endcase
    end

    // Next-state and next-output logic; pulse outputs default low, others hold.
    always_comb begin
        state_d     = state_q;
        pl_d        = pl_q;
        ready_d     = ready_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wen_d   = mem_wen_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        gpr_wen_d   = 1'b0;
        gpr_waddr_d = gpr_waddr_q;
        gpr_wdata_d = gpr_wdata_q;
        csr_wen_d   = 1'b0;
        csr_waddr_d = csr_waddr_q;
        csr_wdata_d = csr_wdata_q;
        finish_d    = 1'b0;
        frd_d       = frd_q;
        err_d       = 1'b0;
        errtp_d     = errtp_q;
        epc_d       = epc_q;
        enter_wb    = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (abt_valid && ready_q) begin
                    pl_d    = in_pl;
                    ready_d = 1'b0;
                    if (!in_pl.men || cur_mis) begin
                        state_d  = S_WB;
                        enter_wb = 1'b1;
                    end else begin
                        state_d     = S_REQ;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {in_pl.addr[31:2], 2'b00};
                        mem_wen_d   = in_pl.write;
                        mem_wdata_d = in_pl.wdata << {in_pl.addr[1:0], 3'b000};
                        mem_wstrb_d = strb;
                    end
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (mem_rvalid) begin
                    state_d  = S_WB;
                    enter_wb = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
        if (enter_wb) begin
            finish_d    = 1'b1;
            frd_d       = cur_pl.ard;
            gpr_wen_d   = cur_pl.gen & (cur_pl.ard != 5'd0) & ~is_store & ~fault;
            gpr_waddr_d = cur_pl.ard;
            gpr_wdata_d = is_load ? load_data : cur_pl.rd;
            csr_wen_d   = cur_pl.sen & ~fault;
            csr_waddr_d = cur_pl.acsr;
            csr_wdata_d = cur_pl.csr;
            err_d       = fault;
            if (fault) begin
                errtp_d = cur_mis ? (cur_pl.write ? 4'd6 : 4'd4)
                                  : (cur_pl.write ? 4'd7 : 4'd5);
                epc_d   = cur_pl.pc;
            end
        end
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pl_q        <= '0;
            ready_q     <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wen_q   <= 1'b0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            gpr_wen_q   <= 1'b0;
            gpr_waddr_q <= '0;
            gpr_wdata_q <= '0;
            csr_wen_q   <= 1'b0;
            csr_waddr_q <= '0;
            csr_wdata_q <= '0;
            finish_q    <= 1'b0;
            frd_q       <= '0;
            err_q       <= 1'b0;
            errtp_q     <= '0;
            epc_q       <= '0;
        end else begin
            state_q     <= state_d;
            pl_q        <= pl_d;
            ready_q     <= ready_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wen_q   <= mem_wen_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            gpr_wen_q   <= gpr_wen_d;
            gpr_waddr_q <= gpr_waddr_d;
            gpr_wdata_q <= gpr_wdata_d;
            csr_wen_q   <= csr_wen_d;
            csr_waddr_q <= csr_waddr_d;
            csr_wdata_q <= csr_wdata_d;
            finish_q    <= finish_d;
            frd_q       <= frd_d;
            err_q       <= err_d;
            errtp_q     <= errtp_d;
            epc_q       <= epc_d;
        end
    end

    assign abt_ready  = ready_q;
    assign abt_finish = finish_q;
    assign abt_frd    = frd_q;
    assign mem_valid  = mem_valid_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wen    = mem_wen_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign gpr_wen    = gpr_wen_q;
    assign gpr_waddr  = gpr_waddr_q;
    assign gpr_wdata  = gpr_wdata_q;
    assign csr_wen    = csr_wen_q;
    assign csr_waddr  = csr_waddr_q;
    assign csr_wdata  = csr_wdata_q;
    assign lsu_err    = err_q;
    assign lsu_errtp  = errtp_q;
    assign lsu_epc    = epc_q;
    assign dbg_state  = state_q;

endmodule
